// File: rtl/npu_pkg.sv
// Shared constants and the feeder state encoding for the score feeder and
// its optional scaler.
package npu_pkg;

  localparam int DEFAULT_DATA_WIDTH  = 8;
  localparam int DEFAULT_MAX_SEQ_LEN = 16;

  typedef enum logic [2:0] {
    FS_IDLE,
    FS_LOAD,
    FS_START,
    FS_WAIT,
    FS_DONE
  } feeder_state_e;

endpackage

// File: rtl/score_scaler.sv
// Combinational arithmetic right shift with round-half-up and int8 clamp.
// Instantiated by score_feeder only when SCORE_FEEDER_SCALE_EN is defined.
module score_scaler #(
  parameter int DATA_WIDTH = 8
) (
  input  logic signed [DATA_WIDTH-1:0] din,
  input  logic        [2:0]            shift,
  output logic signed [DATA_WIDTH-1:0] dout
);

  // Two guard bits keep the rounding add from wrapping before the clamp.
  localparam int WW = DATA_WIDTH + 2;
  localparam logic signed [WW-1:0] SAT_MAX = 127;
  localparam logic signed [WW-1:0] SAT_MIN = -128;

  function automatic logic signed [WW-1:0] round_shift(
    input logic signed [DATA_WIDTH-1:0] v,
    input logic        [2:0]            sh
  );
    logic signed [WW-1:0] w;
    w = {{2{v[DATA_WIDTH-1]}}, v};
    if (sh != 3'd0) begin
      w = w + (WW'(1) <<< (sh - 3'd1));
    end
    return w >>> sh;
  endfunction

  function automatic logic signed [DATA_WIDTH-1:0] sat_int8(
    input logic signed [WW-1:0] w
  );
    if (w > SAT_MAX) begin
      return DATA_WIDTH'(SAT_MAX);
    end
    if (w < SAT_MIN) begin
      return DATA_WIDTH'(SAT_MIN);
    end
    return DATA_WIDTH'(w);
  endfunction

  assign dout = sat_int8(round_shift(din, shift));

endmodule

// File: rtl/score_feeder.sv
// Streams a row-major score matrix (full or lower-triangular) into a softmax
// engine, then starts it and waits for completion. SCORE_FEEDER_SCALE_EN adds
// a rounding/saturating right shift on every beat.
module score_feeder
  import npu_pkg::*;
#(
  parameter int DATA_WIDTH  = DEFAULT_DATA_WIDTH,
  parameter int MAX_SEQ_LEN = DEFAULT_MAX_SEQ_LEN,
  localparam int IDX_W      = $clog2(MAX_SEQ_LEN)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         cmd_valid,
  output logic                         cmd_ready,
  input  logic        [IDX_W-1:0]      cmd_seq_len,
  input  logic                         cmd_causal,
  input  logic        [2:0]            cmd_shift,
  input  logic                         s_valid,
  output logic                         s_ready,
  input  logic signed [DATA_WIDTH-1:0] s_data,
  output logic signed [DATA_WIDTH-1:0] sm_data,
  output logic                         sm_data_valid,
  output logic        [IDX_W-1:0]      sm_row,
  output logic        [IDX_W-1:0]      sm_col,
  output logic        [IDX_W-1:0]      sm_seq_len,
  output logic                         sm_causal,
  output logic                         sm_start,
  input  logic                         sm_busy,
  input  logic                         sm_done,
  output logic                         busy,
  output logic                         done,
  output logic                         err
);

  feeder_state_e state_q, state_d;
  logic [IDX_W-1:0] row_q, row_d, col_q, col_d;
  logic [IDX_W-1:0] seq_len_q, seq_len_d;
  logic causal_q, causal_d;
  logic signed [DATA_WIDTH-1:0] sm_data_q, sm_data_d;
  logic [IDX_W-1:0] sm_row_q, sm_row_d, sm_col_q, sm_col_d;
  logic sm_vld_q, sm_vld_d;
  logic err_q, err_d;
  logic signed [DATA_WIDTH-1:0] scaled;
  logic last_col, last_row;

`ifdef SCORE_FEEDER_SCALE_EN
  logic [2:0] shift_q, shift_d;

  always_comb begin
    shift_d = shift_q;
    if (state_q == FS_IDLE && cmd_valid) begin
      shift_d = cmd_shift;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      shift_q <= 3'd0;
    end else begin
      shift_q <= shift_d;
    end
  end

  score_scaler #(.DATA_WIDTH(DATA_WIDTH)) u_scaler (
    .din   (s_data),
    .shift (shift_q),
    .dout  (scaled)
  );
`else
  logic unused_shift;
  assign unused_shift = ^cmd_shift;
  assign scaled       = s_data;
`endif

  // Terminal column is the diagonal in causal mode, the last column otherwise.
  assign last_col = causal_q ? (col_q == row_q) : (col_q == seq_len_q - IDX_W'(1));
  assign last_row = (row_q == seq_len_q - IDX_W'(1));

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    col_d     = col_q;
    seq_len_d = seq_len_q;
    causal_d  = causal_q;
    sm_data_d = sm_data_q;
    sm_row_d  = sm_row_q;
    sm_col_d  = sm_col_q;
    sm_vld_d  = 1'b0;
    err_d     = 1'b0;
    cmd_ready = 1'b0;
    s_ready   = 1'b0;
    sm_start  = 1'b0;
    done      = 1'b0;
    case (state_q)
      FS_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          seq_len_d = cmd_seq_len;
          causal_d  = cmd_causal;
          row_d     = '0;
          col_d     = '0;
          if (cmd_seq_len == '0) begin
            err_d   = 1'b1;
            state_d = FS_DONE;
          end else begin
            state_d = FS_LOAD;
          end
        end
      end
      FS_LOAD: begin
        s_ready = 1'b1;
        if (s_valid) begin
          sm_data_d = scaled;
          sm_row_d  = row_q;
          sm_col_d  = col_q;
          sm_vld_d  = 1'b1;
          if (last_col) begin
            col_d = '0;
            if (last_row) begin
              state_d = FS_START;
            end else begin
              row_d = row_q + IDX_W'(1);
            end
          end else begin
            col_d = col_q + IDX_W'(1);
          end
        end
      end
      FS_START: begin
        // Hold off until the final beat has left the output register.
        if (!sm_busy && !sm_vld_q) begin
          sm_start = 1'b1;
          state_d  = FS_WAIT;
        end
      end
      FS_WAIT: begin
        if (sm_done) begin
          state_d = FS_DONE;
        end
      end
      FS_DONE: begin
        done    = 1'b1;
        state_d = FS_IDLE;
      end
      default: state_d = FS_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= FS_IDLE;
      row_q     <= '0;
      col_q     <= '0;
      seq_len_q <= '0;
      causal_q  <= 1'b0;
      sm_data_q <= '0;
      sm_row_q  <= '0;
      sm_col_q  <= '0;
      sm_vld_q  <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      col_q     <= col_d;
      seq_len_q <= seq_len_d;
      causal_q  <= causal_d;
      sm_data_q <= sm_data_d;
      sm_row_q  <= sm_row_d;
      sm_col_q  <= sm_col_d;
      sm_vld_q  <= sm_vld_d;
      err_q     <= err_d;
    end
  end

  assign sm_data       = sm_data_q;
  assign sm_data_valid = sm_vld_q;
  assign sm_row        = sm_row_q;
  assign sm_col        = sm_col_q;
  assign sm_seq_len    = seq_len_q;
  assign sm_causal     = causal_q;
  assign busy          = (state_q != FS_IDLE);
  assign err           = err_q;

endmodule

// File: tb/tb_score_feeder.sv
// Randomized self-checking bench for score_feeder; expected beats come from a
// nested-loop matrix walk and an exact real-valued rounding model.
module tb_score_feeder;

  localparam int DW    = 8;
  localparam int IDX_W = 4;

  logic clk = 1'b0;
  logic rst;
  logic cmd_valid;
  logic cmd_ready;
  logic [IDX_W-1:0] cmd_seq_len;
  logic cmd_causal;
  logic [2:0] cmd_shift;
  logic s_valid;
  logic s_ready;
  logic signed [DW-1:0] s_data;
  logic signed [DW-1:0] sm_data;
  logic sm_data_valid;
  logic [IDX_W-1:0] sm_row, sm_col, sm_seq_len;
  logic sm_causal, sm_start, sm_busy, sm_done;
  logic busy, done, err;

  int total = 0;
  int bad = 0;
  int start_cnt = 0;
  int done_cnt = 0;
  int beat_data[$];
  int exp_row[$];
  int exp_col[$];
  int exp_data[$];

  always #5 clk = ~clk;

  score_feeder #(.DATA_WIDTH(DW), .MAX_SEQ_LEN(16)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_seq_len(cmd_seq_len),
    .cmd_causal(cmd_causal), .cmd_shift(cmd_shift),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .sm_data(sm_data), .sm_data_valid(sm_data_valid), .sm_row(sm_row), .sm_col(sm_col),
    .sm_seq_len(sm_seq_len), .sm_causal(sm_causal), .sm_start(sm_start),
    .sm_busy(sm_busy), .sm_done(sm_done),
    .busy(busy), .done(done), .err(err)
  );

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Ideal value of v / 2^sh rounded half up, clamped to int8.
  function automatic int model(input int v, input int sh);
`ifdef SCORE_FEEDER_SCALE_EN
    real r;
    int q;
    r = $floor(real'(v) / (2.0 ** sh) + 0.5);
    q = int'(r);
    if (q > 127) q = 127;
    if (q < -128) q = -128;
    return q;
`else
    return v + 0 * sh;
`endif
  endfunction

  always @(negedge clk) begin
    if (!rst) begin
      if (sm_data_valid) begin
        if (exp_row.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          check("beat_row", int'(sm_row), exp_row.pop_front());
          check("beat_col", int'(sm_col), exp_col.pop_front());
          check("beat_data", int'(sm_data), exp_data.pop_front());
          if (sm_causal) check("causal_mask", int'(sm_col <= sm_row), 1);
        end
      end
      if (sm_start) begin
        start_cnt++;
        check("start_not_busy", int'(sm_busy), 0);
      end
      if (done) done_cnt++;
    end
  end

  task automatic fill_seq(input int n);
    beat_data.delete();
    for (int i = 0; i < n; i++) beat_data.push_back(i + 1);
  endtask

  task automatic fill_rand(input int n);
    beat_data.delete();
    for (int i = 0; i < n; i++) beat_data.push_back(int'($urandom_range(0, 255)) - 128);
  endtask

  task automatic send_cmd(input int len, input bit causal, input int shift);
    check("cmd_ready_idle", int'(cmd_ready), 1);
    cmd_valid   = 1'b1;
    cmd_seq_len = IDX_W'(len);
    cmd_causal  = causal;
    cmd_shift   = 3'(shift);
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  // vmode: 0 back-to-back, 1 toggling, 2 random valid.
  task automatic run_cmd(input int len, input bit causal, input int shift,
                         input int vmode, input int busy_hold);
    int n, idx, cyc, start0, done0;
    bit xfer, seen;
    n = 0;
    for (int r = 0; r < len; r++) begin
      for (int c = 0; c < (causal ? r + 1 : len); c++) begin
        exp_row.push_back(r);
        exp_col.push_back(c);
        exp_data.push_back(model(beat_data[n], shift));
        n++;
      end
    end
    start0  = start_cnt;
    done0   = done_cnt;
    sm_busy = (busy_hold > 0);
    send_cmd(len, causal, shift);
    check("busy_after_cmd", int'(busy), 1);
    check("sm_seq_len", int'(sm_seq_len), len);
    check("sm_causal", int'(sm_causal), int'(causal));
    if (vmode == 1) begin
      cmd_valid   = 1'b1;
      cmd_seq_len = '0;
    end
    idx = 0;
    cyc = 0;
    while (idx < n && cyc < 1000) begin
      s_valid = (vmode == 0) ? 1'b1 : (vmode == 1) ? (cyc % 2 == 0) : 1'($urandom_range(0, 1));
      s_data  = DW'(beat_data[idx]);
      @(negedge clk);
      if (vmode == 1) check("cmd_ready_busy", int'(cmd_ready), 0);
      xfer = s_valid && s_ready;
      @(posedge clk); #1;
      if (xfer) idx++;
      cyc++;
    end
    s_valid = 1'b0;
    check("beats_loaded", idx, n);
    if (vmode == 1) check("toggle_cycles", cyc, 2 * n - 1);
    check("s_ready_after_last", int'(s_ready), 0);
    seen = 1'b0;
    if (busy_hold > 0) begin
      repeat (busy_hold) begin
        @(negedge clk);
        check("start_held", int'(sm_start), 0);
        @(posedge clk); #1;
      end
      sm_busy = 1'b0;
      @(negedge clk);
      check("start_on_busy_fall", int'(sm_start), 1);
      seen = sm_start;
    end else begin
      for (int i = 0; i < 50 && !seen; i++) begin
        @(negedge clk);
        seen = sm_start;
      end
      check("start_seen", int'(seen), 1);
    end
    @(posedge clk); #1;
    repeat ($urandom_range(0, 3)) begin
      check("no_early_done", int'(done), 0);
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    sm_done   = 1'b1;
    @(posedge clk); #1;
    sm_done = 1'b0;
    check("done_pulse", int'(done), 1);
    check("err_clear", int'(err), 0);
    check("seq_len_held", int'(sm_seq_len), len);
    @(posedge clk); #1;
    check("done_one_cycle", int'(done), 0);
    check("idle_not_busy", int'(busy), 0);
    check("beats_left", exp_row.size(), 0);
    check("start_count", start_cnt - start0, 1);
    check("done_count", done_cnt - done0, 1);
  endtask

  task automatic check_reset_outputs();
    check("rst_valid", int'(sm_data_valid), 0);
    check("rst_data", int'(sm_data), 0);
    check("rst_row", int'(sm_row), 0);
    check("rst_col", int'(sm_col), 0);
    check("rst_seq_len", int'(sm_seq_len), 0);
    check("rst_causal", int'(sm_causal), 0);
    check("rst_start", int'(sm_start), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_done", int'(done), 0);
    check("rst_err", int'(err), 0);
    check("rst_s_ready", int'(s_ready), 0);
  endtask

  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_seq_len = '0; cmd_causal = 1'b0; cmd_shift = '0;
    s_valid = 1'b0; s_data = '0; sm_busy = 1'b0; sm_done = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_reset_outputs();
    @(posedge clk); #1;
    rst = 1'b0;
    check("cmd_ready_after_rst", int'(cmd_ready), 1);

    sm_done = 1'b1;
    @(posedge clk); #1;
    sm_done = 1'b0;
    check("stray_sm_done", int'(busy) + int'(done), 0);

    fill_seq(9);  run_cmd(3, 1'b0, 0, 0, 0);
    fill_rand(10); run_cmd(4, 1'b1, 0, 0, 0);
    fill_rand(4); run_cmd(2, 1'b0, 0, 1, 0);
    fill_rand(4); run_cmd(2, 1'b0, 0, 0, 5);

    send_cmd(0, 1'b0, 0);
    @(negedge clk);
    check("zero_len_done", int'(done), 1);
    check("zero_len_err", int'(err), 1);
    @(posedge clk); #1;
    check("zero_len_err_pulse", int'(err), 0);
    check("zero_len_idle", int'(busy), 0);

    beat_data.delete();
    beat_data.push_back(7); beat_data.push_back(-7);
    beat_data.push_back(127); beat_data.push_back(-128);
    run_cmd(2, 1'b0, 2, 0, 0);

    fill_rand(3);
    for (int i = 0; i < 3; i++) begin
      exp_row.push_back(0); exp_col.push_back(i); exp_data.push_back(beat_data[i]);
    end
    send_cmd(4, 1'b0, 0);
    for (int i = 0; i < 3; i++) begin
      s_valid = 1'b1;
      s_data  = DW'(beat_data[i]);
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("mid_load_beats", 3 - exp_row.size(), 3);
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs();
    exp_row.delete(); exp_col.delete(); exp_data.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    fill_rand(4); run_cmd(2, 1'b0, 0, 0, 0);

    for (int k = 0; k < 8; k++) begin
      int len;
      bit causal;
      len    = int'($urandom_range(1, 6));
      causal = 1'($urandom_range(0, 1));
      fill_rand(len * len);
      run_cmd(len, causal, int'($urandom_range(0, 7)), int'($urandom_range(0, 2)),
              int'($urandom_range(0, 3)));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
